mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter OPW, default 4, the operand width; RESW = 2*OPW, the result width.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports req0_valid (in, 1), req0_ready (out, 1), req0_a (in, OPW), req0_b (in, OPW): requester 0 handshake and operands.
REQ-005 SHALL have ports req1_valid (in, 1), req1_ready (out, 1), req1_a (in, OPW), req1_b (in, OPW): requester 1 handshake and operands.
REQ-006 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_data (out, RESW), rsp_id (out, 1): response handshake, product, and the index of the requester that issued it.
REQ-007 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-008 SHALL have port txn_count, output, 8: count of completed responses.

Function
REQ-009 SHALL implement an FSM with states IDLE, CALC, RESP.
REQ-010 In IDLE, SHALL grant at most one requester per cycle; the granted requester's ready is high combinationally and every other ready is low.
REQ-011 Arbitration SHALL be round-robin: if only one valid is high, that requester is granted; if both are high, the requester not named by last_grant is granted.
REQ-012 On an accept (valid&ready), SHALL register the operands and the requester id, update last_grant to that id, and move to CALC.
REQ-013 Both readys SHALL be low in CALC and RESP; requests are not queued.
REQ-014 In CALC, SHALL register the unsigned product of the captured operands into rsp_data (RESW bits, no truncation), set rsp_valid, and move to RESP after exactly one cycle.
REQ-015 Latency SHALL be: accept at edge N, rsp_valid high from edge N+2.
REQ-016 In RESP, rsp_valid, rsp_data and rsp_id SHALL hold stable until rsp_ready is sampled high.
REQ-017 On the rsp_ready handshake, SHALL clear rsp_valid, increment txn_count (modulo 256, 255 wraps to 0), and return to IDLE.
REQ-018 A new accept SHALL occur no earlier than the cycle after returning to IDLE, giving a maximum throughput of one transaction per 3 cycles.
REQ-019 Changes on operand inputs while ready is low SHALL have no effect.
REQ-020 When no valid is high in IDLE, SHALL remain in IDLE and leave last_grant unchanged.

Reset
REQ-021 When rst is high at a clock edge, SHALL enter IDLE and clear rsp_valid, rsp_data, rsp_id, txn_count and the operand registers to 0.
REQ-022 Reset SHALL set last_grant to 1, so requester 0 wins the first contention.
REQ-023 Reset asserted in CALC or RESP SHALL discard the transaction, with no response and no txn_count increment.
REQ-024 Both readys SHALL be low during any cycle in which rst is high.

Structure
REQ-025 Shared package mult_pkg SHALL hold the state enum (IDLE/CALC/RESP), OPW and RESW.
REQ-026 The product SHALL come from one instantiated sub-module, array_mult4x4: a combinational OPW x OPW unsigned array multiplier built from full-adder rows.
REQ-027 The arbiter, FSM and registers SHALL reside in mult_arbiter; the multiplier is shared by time-multiplexing only.

Verification
REQ-028 Reset: hold rst for 2 cycles, then release with valids low -> busy=0, rsp_valid=0, txn_count=0, both readys 0.
REQ-029 Single request: req0 3x5, rsp_ready=1 -> rsp_data=15 and rsp_id=0 with rsp_valid high exactly 2 edges after the accept; txn_count becomes 1.
REQ-030 Contention: both valid from reset, req0 15x15 and req1 0x7 -> req0 served first (225, id 0), then req1 (0, id 1); with both held valid, grants alternate 0,1,0,1.
REQ-031 Backpressure: req1 9x9 with rsp_ready=0 for 5 cycles -> rsp_data=81 and rsp_id=1 held stable, readys low; completes one cycle after rsp_ready rises.
REQ-032 Reset mid-op: assert rst in CALC -> no response and txn_count unchanged; the next contention goes to req0.
REQ-033 Wrap: 256 completed transactions -> txn_count reads 0.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and widths for the arbitrated multiplier
package mult_pkg;

    localparam int OPW  = 4;
    localparam int RESW = 2 * OPW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/array_mult4x4.sv
// rtl/array_mult4x4.sv - combinational unsigned array multiplier from full-adder rows
module array_mult4x4 #(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic [2*OPW-1:0] product
);

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    logic [OPW-1:0] acc;
    logic [OPW-1:0] shifted;
    logic           carry_row;
    logic           c;
    logic [1:0]     fa;

    // Each row adds one partial product to the previous row shifted down by one;
    // the bit falling out of the bottom of each row is a final product bit.
    always_comb begin
        acc       = a & {OPW{b[0]}};
        carry_row = 1'b0;
        shifted   = '0;
        c         = 1'b0;
        fa        = '0;
        product   = '0;
        product[0] = acc[0];
        for (int i = 1; i < OPW; i++) begin
            shifted = {carry_row, acc[OPW-1:1]};
            c       = 1'b0;
            for (int j = 0; j < OPW; j++) begin
                fa     = full_add(shifted[j], a[j] & b[i], c);
                acc[j] = fa[0];
                c      = fa[1];
            end
            carry_row  = c;
            product[i] = acc[0];
        end
        product[2*OPW-1:OPW] = {carry_row, acc[OPW-1:1]};
    end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-requester round-robin front end to one shared multiplier
module mult_arbiter #(
    parameter int OPW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_a,
    input  logic [OPW-1:0]   req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_a,
    input  logic [OPW-1:0]   req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2*OPW-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [7:0]       txn_count
);

    import mult_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [OPW-1:0]   op_a;
    logic [OPW-1:0]   op_b;
    logic [2*OPW-1:0] product;

    // On contention the requester not served last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            grant0 = req0_valid && (!req1_valid || last_grant);
            grant1 = req1_valid && (!req0_valid || !last_grant);
        end
    end

    assign accept = grant0 | grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = CALC;
            CALC:                   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_valid  <= 1'b0;
            txn_count  <= 8'd0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= grant1 ? req1_a : req0_a;
                        op_b       <= grant1 ? req1_b : req0_b;
                        rsp_id     <= grant1;
                        last_grant <= grant1;
                    end
                end
                CALC: begin
                    rsp_data  <= product;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    array_mult4x4 #(.OPW(OPW)) u_mult (
        .a       (op_a),
        .b       (op_b),
        .product (product)
    );

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - randomized self-checking bench against a transaction-level model
module tb_mult_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_id;
    logic       busy;
    logic [7:0] txn_count;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: a transaction is pending from its accept until its response handshakes;
    // m_age counts edges since the accept (response visible once two have passed).
    bit         m_busy;
    int         m_age;
    logic [7:0] m_data;
    logic       m_id;
    logic       m_last;
    logic [7:0] m_count;
    int         completions;
    bit         grants[$];

    mult_arbiter #(.OPW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .txn_count  (txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                        input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic rr);
        logic g0, g1, exp_valid;
        @(negedge clk);
        rst = r; req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1; rsp_ready = rr;
        #1;
        g0 = !r && !m_busy && v0 && (!v1 || m_last);
        g1 = !r && !m_busy && v1 && (!v0 || !m_last);
        exp_valid = m_busy && (m_age >= 2);
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        check("busy", busy, m_busy);
        check("rsp_valid", rsp_valid, exp_valid);
        check("txn_count", txn_count, m_count);
        if (exp_valid) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", rsp_id, m_id);
        end
        if (r) begin
            m_busy = 0; m_age = 0; m_count = 0; m_last = 1'b1;
        end else if (!m_busy) begin
            if (g0 || g1) begin
                m_busy = 1; m_age = 1; m_id = g1; m_last = g1;
                m_data = g1 ? a1 * b1 : a0 * b0;
                grants.push_back(g1);
            end
        end else if (m_age >= 2 && rr) begin
            m_busy = 0; m_age = 0; m_count = m_count + 8'd1; completions++;
        end else begin
            m_age = (m_age < 3) ? m_age + 1 : 3;
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_busy = 0; m_age = 0; m_data = 0; m_id = 0; m_last = 1; m_count = 0; completions = 0;
        rst = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;

        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_rsp_data", rsp_data, 0);

        // Single request 3x5: visible two edges after the accept
        grants.delete();
        step(0, 1, 3, 5, 0, 0, 0, 1);
        step(0, 0, 9, 9, 0, 0, 0, 1);
        check("single_not_yet", rsp_valid, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("single_data", rsp_data, 15);
        check("single_id", rsp_id, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("single_count", txn_count, 1);

        // Contention from reset, both held valid
        do_reset();
        grants.delete();
        for (int i = 0; i < 13; i++) step(0, 1, 15, 15, 1, 0, 7, 1);
        check("contend_ngrants", grants.size() >= 4, 1);
        if (grants.size() >= 4) begin
            check("grant_seq0", grants[0], 0);
            check("grant_seq1", grants[1], 1);
            check("grant_seq2", grants[2], 0);
            check("grant_seq3", grants[3], 1);
        end

        // Backpressure on req1 9x9
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 9, 9, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2, 2, 1, 3, 3, 0);
        check("bp_data", rsp_data, 81);
        check("bp_id", rsp_id, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("bp_done", rsp_valid, 0);

        // Reset while in CALC discards the transaction
        step(0, 1, 7, 7, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("midop_no_rsp", rsp_valid, 0);
        check("midop_count", txn_count, 0);
        grants.delete();
        step(0, 1, 4, 4, 1, 5, 5, 1);
        check("midop_first_grant", req0_ready, 1);
        check("midop_grant_id", grants.size() == 1 && grants[0] == 0, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), 4'($urandom), 4'($urandom),
                 $urandom_range(0, 1), 4'($urandom), 4'($urandom), ($urandom_range(0, 9) < 7));
        end

        // 256 completions wrap the counter
        do_reset();
        completions = 0;
        for (int i = 0; i < 1000 && completions < 256; i++) begin
            step(0, 1, 4'($urandom), 4'($urandom), 1, 4'($urandom), 4'($urandom), 1);
        end
        check("wrap_completions", completions, 256);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("wrap_count", txn_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
